// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word memory between an instruction fetch
// port and a load/store port. It arbitrates round-robin, does read-modify-write
// for byte and halfword stores, extends sub-word loads and rejects misaligned
// load/store accesses without touching memory.
//
// Ports
//   clk, reset            clock and synchronous active-low reset
//   halt                  blocks new grants; in-flight work completes
//   fe_req/fe_addr        fetch request, byte address
//   fe_gnt/fe_valid/fe_data   fetch accept, fetch data return
//   ls_req/ls_we/ls_size/ls_addr/ls_wdata/ls_rd_sel   load/store request
//   ls_gnt/ls_valid/ls_rdata/ls_rd_sel_o/ls_err       load/store accept, completion
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata        word memory, 1-cycle read latency
//   busy                  a transaction is in flight
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a request; grant and first memory access happen here
// RD_WAIT | read data on mem_rdata, returned to the granted port
// RMW_WR  | old word on mem_rdata, merged sub-word store written back
// DONE    | word store finished or misaligned access; ls_valid pulse
module mem_arbiter #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  input  logic              fe_req,
  input  logic [ADDR_W-1:0] fe_addr,
  output logic              fe_gnt,
  output logic              fe_valid,
  output logic [WIDTH-1:0]  fe_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [WIDTH-1:0]  ls_wdata,
  input  logic [4:0]        ls_rd_sel,
  output logic              ls_gnt,
  output logic              ls_valid,
  output logic [WIDTH-1:0]  ls_rdata,
  output logic [4:0]        ls_rd_sel_o,
  output logic              ls_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] RMW_WR  = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]        state, state_nxt;
  logic              rr_fe;      // 1: fetch wins the next tie
  logic              is_ls_q;
  logic              err_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;    // only sub-word stores use the latched data
  logic [4:0]        rd_sel_q;

  logic              grant_ok;
  logic              ls_mis;
  logic [31:0]       load_fmt;
  logic [31:0]       lane_mask;
  logic [31:0]       lane_data;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  assign grant_ok = reset && (state == IDLE) && !halt;
  assign ls_gnt   = grant_ok && ls_req && (!fe_req || !rr_fe);
  assign fe_gnt   = grant_ok && fe_req && !ls_gnt;
  assign busy     = reset && (state != IDLE);

  always_comb begin
    case (ls_size)
      3'd0, 3'd4: ls_mis = 1'b0;
      3'd1, 3'd5: ls_mis = ls_addr[0];
      3'd2:       ls_mis = |ls_addr[1:0];
      default:    ls_mis = 1'b1;
    endcase
  end

  // Load extraction from the word returned in RD_WAIT.
  always_comb begin
    byte_sel = 8'(mem_rdata >> {addr_q[1:0], 3'b000});
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      3'd0:    load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'd4:    load_fmt = {24'h0, byte_sel};
      3'd1:    load_fmt = {{16{half_sel[15]}}, half_sel};
      3'd5:    load_fmt = {16'h0, half_sel};
      default: load_fmt = mem_rdata;
    endcase
  end

  // Sub-word store: replicate the data to every lane, then keep only the
  // addressed lane and take the rest from the old word.
  always_comb begin
    if (!size_q[0]) begin
      lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
      lane_data = {4{wdata_q[7:0]}};
    end else begin
      lane_mask = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      lane_data = {2{wdata_q}};
    end
  end

  always_comb begin
    state_nxt   = state;
    fe_valid    = 1'b0;
    fe_data     = '0;
    ls_valid    = 1'b0;
    ls_rdata    = '0;
    ls_rd_sel_o = '0;
    ls_err      = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state)
      IDLE: begin
        if (ls_gnt) begin
          if (ls_mis) begin
            state_nxt = DONE;
          end else begin
            mem_en   = 1'b1;
            mem_addr = ls_addr[ADDR_W-1:2];
            if (ls_we && ls_size == 3'd2) begin
              mem_we    = 1'b1;
              mem_wdata = ls_wdata;
              state_nxt = DONE;
            end else if (ls_we) begin
              state_nxt = RMW_WR;
            end else begin
              state_nxt = RD_WAIT;
            end
          end
        end else if (fe_gnt) begin
          mem_en    = 1'b1;
          mem_addr  = fe_addr[ADDR_W-1:2];
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (is_ls_q) begin
          ls_valid    = 1'b1;
          ls_rdata    = load_fmt;
          ls_rd_sel_o = rd_sel_q;
        end else begin
          fe_valid = 1'b1;
          fe_data  = mem_rdata;
        end
        state_nxt = IDLE;
      end
      RMW_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q[ADDR_W-1:2];
        mem_wdata = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);
        state_nxt = DONE;
      end
      default: begin
        ls_valid    = 1'b1;
        ls_err      = err_q;
        ls_rd_sel_o = rd_sel_q;
        state_nxt   = IDLE;
      end
    endcase
    // Reset silences every output in the cycle it is sampled, so an
    // interrupted RMW never reaches memory.
    if (!reset) begin
      state_nxt   = IDLE;
      fe_valid    = 1'b0;
      fe_data     = '0;
      ls_valid    = 1'b0;
      ls_rdata    = '0;
      ls_rd_sel_o = '0;
      ls_err      = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      rr_fe    <= 1'b0;
      is_ls_q  <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_sel_q <= '0;
    end else begin
      state <= state_nxt;
      if (ls_gnt) begin
        rr_fe    <= 1'b1;
        is_ls_q  <= 1'b1;
        err_q    <= ls_mis;
        size_q   <= ls_size;
        addr_q   <= ls_addr;
        wdata_q  <= ls_wdata[15:0];
        rd_sel_q <= ls_rd_sel;
      end else if (fe_gnt) begin
        rr_fe    <= 1'b0;
        is_ls_q  <= 1'b0;
        err_q    <= 1'b0;
        addr_q   <= fe_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors with hand-computed results for mem_arbiter,
// backed by a 256-word memory with one-cycle read latency.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        halt;
  logic        fe_req;
  logic [9:0]  fe_addr;
  logic        fe_gnt, fe_valid;
  logic [31:0] fe_data;
  logic        ls_req, ls_we;
  logic [2:0]  ls_size;
  logic [9:0]  ls_addr;
  logic [31:0] ls_wdata;
  logic [4:0]  ls_rd_sel;
  logic        ls_gnt, ls_valid, ls_err;
  logic [31:0] ls_rdata;
  logic [4:0]  ls_rd_sel_o;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        busy;

  logic [31:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.WIDTH(32), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .fe_req(fe_req), .fe_addr(fe_addr), .fe_gnt(fe_gnt),
    .fe_valid(fe_valid), .fe_data(fe_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rd_sel(ls_rd_sel), .ls_gnt(ls_gnt),
    .ls_valid(ls_valid), .ls_rdata(ls_rdata), .ls_rd_sel_o(ls_rd_sel_o),
    .ls_err(ls_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    step();
    pre_we   = 1'b0;
  endtask

  // Issues one load/store, checks the grant cycle, then scrambles the request
  // inputs so later cycles only see latched values. Returns in cycle T+1.
  task automatic ls_op(input logic we, input logic [2:0] size, input logic [9:0] addr,
                       input logic [31:0] wd, input logic [4:0] sel,
                       input logic exp_en, input logic exp_we);
    ls_req = 1'b1; ls_we = we; ls_size = size; ls_addr = addr;
    ls_wdata = wd; ls_rd_sel = sel;
    #1;
    check("ls_gnt", ls_gnt, 1);
    check("grant_mem_en", mem_en, exp_en);
    check("grant_mem_we", mem_we, exp_we);
    if (exp_en) check("grant_mem_addr", mem_addr, 32'(addr >> 2));
    step();
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 3'd7; ls_addr = '1;
    ls_wdata = '1; ls_rd_sel = '1;
    #1;
  endtask

  task automatic do_load(input logic [2:0] size, input logic [9:0] addr,
                         input logic [4:0] sel, input logic [31:0] exp);
    ls_op(1'b0, size, addr, 32'h0, sel, 1'b1, 1'b0);
    check("load_valid", ls_valid, 1);
    check("load_rdata", ls_rdata, exp);
    check("load_tag", ls_rd_sel_o, 32'(sel));
    check("load_err", ls_err, 0);
    step();
  endtask

  initial begin
    reset = 1'b0; halt = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    fe_req = 1'b1; fe_addr = '0;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 3'd2; ls_addr = '0;
    ls_wdata = '0; ls_rd_sel = '0;
    step(); step();
    check("rst_ls_gnt", ls_gnt, 0);
    check("rst_fe_gnt", fe_gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_ls_valid", ls_valid, 0);
    fe_req = 1'b0; ls_req = 1'b0; reset = 1'b1;
    poke(8'd4, 32'hCAFE_BABE);
    poke(8'd0, 32'h1122_3344);
    poke(8'd1, 32'h0000_F080);
    poke(8'd2, 32'h5566_7788);

    // fetch 0x010
    fe_req = 1'b1; fe_addr = 10'h010; #1;
    check("fe_gnt", fe_gnt, 1);
    check("fe_ls_gnt", ls_gnt, 0);
    check("fe_mem_en", mem_en, 1);
    check("fe_mem_we", mem_we, 0);
    check("fe_mem_addr", mem_addr, 32'h4);
    step();
    fe_req = 1'b0; fe_addr = '0; #1;
    check("fe_valid", fe_valid, 1);
    check("fe_data", fe_data, 32'hCAFE_BABE);
    check("fe_busy", busy, 1);
    step();
    check("fe_valid_drop", fe_valid, 0);
    check("fe_data_zero", fe_data, 0);
    check("fe_idle_busy", busy, 0);

    // misaligned fetch drops the low bits
    fe_req = 1'b1; fe_addr = 10'h013; #1;
    check("fe_mis_addr", mem_addr, 32'h4);
    step();
    fe_req = 1'b0; #1;
    check("fe_mis_data", fe_data, 32'hCAFE_BABE);
    step();

    // loads from 0x0000F080 at byte address 4
    do_load(3'd0, 10'd4, 5'd7,  32'hFFFF_FF80);
    do_load(3'd5, 10'd4, 5'd8,  32'h0000_F080);
    do_load(3'd1, 10'd4, 5'd9,  32'hFFFF_F080);
    do_load(3'd4, 10'd5, 5'd10, 32'h0000_00F0);
    do_load(3'd0, 10'd7, 5'd11, 32'h0000_0000);
    do_load(3'd2, 10'd4, 5'd12, 32'h0000_F080);

    // SB 0xAB at addr 2 over 0x11223344
    ls_op(1'b1, 3'd0, 10'd2, 32'hFFFF_FFAB, 5'd3, 1'b1, 1'b0);
    check("sb_rmw_en", mem_en, 1);
    check("sb_rmw_we", mem_we, 1);
    check("sb_rmw_addr", mem_addr, 0);
    check("sb_rmw_wdata", mem_wdata, 32'h11AB_3344);
    check("sb_rmw_valid", ls_valid, 0);
    step();
    check("sb_done_valid", ls_valid, 1);
    check("sb_done_err", ls_err, 0);
    check("sb_done_mem_en", mem_en, 0);
    check("sb_done_tag", ls_rd_sel_o, 3);
    step();
    check("sb_mem", mem[0], 32'h11AB_3344);

    // SH 0xBEEF at addr 2
    ls_op(1'b1, 3'd1, 10'd2, 32'h1234_BEEF, 5'd4, 1'b1, 1'b0);
    check("sh_rmw_wdata", mem_wdata, 32'hBEEF_3344);
    step(); step();
    check("sh_mem", mem[0], 32'hBEEF_3344);

    // SW to word 3
    ls_op(1'b1, 3'd2, 10'h00C, 32'h1234_5678, 5'd5, 1'b1, 1'b1);
    check("sw_done_valid", ls_valid, 1);
    check("sw_mem", mem[3], 32'h1234_5678);
    step();

    // misaligned / illegal accesses
    ls_op(1'b0, 3'd2, 10'h006, 32'h0, 5'd9, 1'b0, 1'b0);
    check("lw_mis_valid", ls_valid, 1);
    check("lw_mis_err", ls_err, 1);
    check("lw_mis_rdata", ls_rdata, 0);
    check("lw_mis_tag", ls_rd_sel_o, 9);
    step();
    check("lw_mis_err_drop", ls_err, 0);
    ls_op(1'b0, 3'd3, 10'h000, 32'h0, 5'd1, 1'b0, 1'b0);
    check("size3_err", ls_err, 1);
    step();
    ls_op(1'b1, 3'd1, 10'h001, 32'h0000_5555, 5'd1, 1'b0, 1'b0);
    check("sh_mis_err", ls_err, 1);
    check("sh_mis_mem_en", mem_en, 0);
    step();
    check("sh_mis_mem", mem[0], 32'hBEEF_3344);

    // halt blocks a new grant
    halt = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_size = 3'd2; ls_addr = 10'h0; #1;
    check("halt_gnt", ls_gnt, 0);
    check("halt_mem_en", mem_en, 0);
    step();
    check("halt_gnt2", ls_gnt, 0);
    check("halt_busy", busy, 0);
    halt = 1'b0; #1;
    check("unhalt_gnt", ls_gnt, 1);
    step();
    ls_req = 1'b0; #1;
    check("unhalt_rdata", ls_rdata, 32'hBEEF_3344);
    step();

    // halt raised mid-RMW does not stop it
    ls_op(1'b1, 3'd0, 10'h00C, 32'h0000_0099, 5'd2, 1'b1, 1'b0);
    halt = 1'b1; #1;
    check("halt_rmw_we", mem_we, 1);
    check("halt_rmw_wdata", mem_wdata, 32'h1234_5699);
    step();
    check("halt_rmw_valid", ls_valid, 1);
    step();
    halt = 1'b0;

    // reset during RMW_WR abandons the write
    ls_op(1'b1, 3'd0, 10'h008, 32'h0000_00EE, 5'd2, 1'b1, 1'b0);
    reset = 1'b0; #1;
    check("rstrmw_mem_we", mem_we, 0);
    check("rstrmw_mem_en", mem_en, 0);
    step();
    check("rstrmw_busy", busy, 0);
    check("rstrmw_valid", ls_valid, 0);
    reset = 1'b1; #1;
    check("rstrmw_mem", mem[2], 32'h5566_7788);

    // both requesting after reset: ls, fe, ls, fe
    fe_req = 1'b1; fe_addr = 10'h0;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 3'd2; ls_addr = 10'h0; #1;
    for (int i = 0; i < 4; i++) begin
      check("rr_ls_gnt", ls_gnt, (i % 2 == 0) ? 1 : 0);
      check("rr_fe_gnt", fe_gnt, (i % 2 == 1) ? 1 : 0);
      step(); step();
    end
    fe_req = 1'b0; ls_req = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_W, default 10, byte-address width of fe_addr/ls_addr; mem_addr width is ADDR_W-2.
REQ-003 SHALL have ports, in order:
  - clk  in  1  sole clock, rising edge.
  - reset  in  1  synchronous, active-low: 0 = reset.
  - halt  in  1  blocks new grants.
  - fe_req  in  1  fetch request.
  - fe_addr  in  ADDR_W  fetch byte address.
  - fe_gnt  out  1  fetch accepted.
  - fe_valid  out  1  fetch data valid.
  - fe_data  out  32  fetched word.
  - ls_req  in  1  load/store request.
  - ls_we  in  1  1 = store.
  - ls_size  in  3  RISC-V funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU.
  - ls_addr  in  ADDR_W  byte address.
  - ls_wdata  in  32  store data, right-aligned.
  - ls_rd_sel  in  5  destination register tag.
  - ls_gnt  out  1  load/store accepted.
  - ls_valid  out  1  load/store complete.
  - ls_rdata  out  32  extended load data.
  - ls_rd_sel_o  out  5  tag returned with ls_valid, else 0.
  - ls_err  out  1  misaligned access, pulses with ls_valid.
  - mem_en  out  1  memory access strobe.
  - mem_we  out  1  memory write.
  - mem_addr  out  ADDR_W-2  word address = byte address >> 2.
  - mem_wdata  out  32  full word to memory.
  - mem_rdata  in  32  memory read data, valid the cycle after mem_en with mem_we=0.
  - busy  out  1  state != IDLE.

Function
REQ-004 SHALL implement FSM IDLE, RD_WAIT, RMW_WR, DONE; leaving IDLE only on a grant.
REQ-005 SHALL grant only in IDLE with halt=0; fe_gnt/ls_gnt combinational, one-hot, at most one per cycle.
REQ-006 SHALL arbitrate round-robin: both requesting -> the port not granted last wins; after reset ls has priority.
REQ-007 SHALL, at grant, latch address, ls_we, ls_size, ls_wdata, ls_rd_sel; requester inputs are don't-care afterwards.
REQ-008 SHALL, for fetch or load granted in cycle T: mem_en=1, mem_we=0 in T; -> RD_WAIT; T+1 *_valid=1 with formatted mem_rdata; -> IDLE.
REQ-009 SHALL, for aligned word store at T: mem_en=mem_we=1, mem_wdata=ls_wdata in T; -> DONE; T+1 ls_valid=1; -> IDLE.
REQ-010 SHALL, for aligned B/H store at T: read in T; T+1 (RMW_WR) write merged word, replacing only addressed lanes; T+2 (DONE) ls_valid=1.
REQ-011 SHALL use little-endian lanes: byte lane = addr[1:0], lane 0 = bits 7:0; halfword lane = addr[1].
REQ-012 SHALL sign-extend B/H loads, zero-extend BU/HU; fe_data = mem_rdata unmodified.
REQ-013 SHALL flag misalignment (H/HU with addr[0]=1; W with addr[1:0]!=0; fetch with addr[1:0]!=0 ignored, low bits dropped): no memory access, -> DONE, next cycle ls_valid=1, ls_err=1, ls_rdata=0.
REQ-014 SHALL treat ls_size 3, 6, 7 as misaligned (ls_err).
REQ-015 SHALL drive fe_data, ls_rdata, ls_rd_sel_o, ls_err = 0 whenever the matching valid is 0.
REQ-016 SHALL let halt=1 block only new grants; an in-flight transaction completes normally.
REQ-017 SHALL drive mem_en=mem_we=0 in IDLE without grant and in DONE.

Reset
REQ-018 SHALL, on rising clk with reset=0, enter IDLE, clear round-robin state to ls-priority, force all outputs 0 that cycle, abandoning any in-flight transaction (no RMW write issued).

Verification
REQ-019 Fetch 0x010 -> mem_addr=0x004, fe_valid one cycle later, fe_data=mem_rdata.
REQ-020 fe_req, ls_req both held after reset -> grants ls, fe, ls, fe alternating.
REQ-021 mem word 0x11223344, SB 0xAB at addr 2 -> read, then write 0x11AB3344, ls_valid at T+2.
REQ-022 mem word 0x0000F080, LB addr 0 -> ls_rdata 0xFFFFFF80; LHU addr 0 -> 0x0000F080.
REQ-023 LW addr 0x6 -> no mem_en, ls_valid=1, ls_err=1, ls_rdata=0 at T+1.
REQ-024 reset=0 during RMW_WR -> mem_we=0, busy=0 next cycle, memory unchanged; halt=1 with ls_req -> no ls_gnt until halt=0.
